// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and the state encodings of the BRAM slave FSMs.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_EXEC = 2'd1,
        WR_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_FETCH = 2'd1,
        RD_DATA  = 2'd2
    } rd_state_e;

endpackage

// File: rtl/sdp_bram_be.sv
// Simple-dual-port RAM: one byte-enabled write port, one registered read port
// (read-before-write on the same word). Contents start as byte k = k[7:0].
//   clk, rst_n          : clock, async active-low reset (read register only)
//   we_i/waddr_i/wbe_i/wdata_i : write port with per-byte enables
//   re_i/rclr_i/raddr_i : read enable, synchronous clear of the read register, read index
//   rdata_o             : registered read data
module sdp_bram_be #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 256,
    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8,
    localparam int unsigned IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [NUM_BYTES-1:0]  wbe_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic                  rclr_i,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    typedef logic [DATA_WIDTH-1:0] mem_t [MEM_DEPTH];

    // Power-up image: byte k of the array holds the low 8 bits of k.
    function automatic mem_t init_image();
        mem_t                  img;
        logic [DATA_WIDTH-1:0] word;
        for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
            word = '0;
            for (int unsigned b = 0; b < NUM_BYTES; b++) begin
                // Shift bytes in from the top so byte 0 ends up in the low lane.
                word = (word >> 8) | (DATA_WIDTH'(8'(i * NUM_BYTES + b)) << (DATA_WIDTH - 8));
            end
            img[IDX_W'(i)] = word;
        end
        return img;
    endfunction

    mem_t                  mem_q = init_image();
    logic [DATA_WIDTH-1:0] bmask_c;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Expand byte enables into a bit mask.
    for (genvar b = 0; b < NUM_BYTES; b++) begin : g_mask
        assign bmask_c[8*b +: 8] = {8{wbe_i[b]}};
    end

    // Write port: only enabled lanes change.
    always_ff @(posedge clk) begin : write_port
        if (we_i) begin
            mem_q[waddr_i] <= (mem_q[waddr_i] & ~bmask_c) | (wdata_i & bmask_c);
        end
    end

    // Read port: samples pre-write contents on a same-edge collision.
    always_ff @(posedge clk or negedge rst_n) begin : read_port
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= rclr_i ? '0 : mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_lite_bram_wide.sv
// AXI4-Lite slave in front of a byte-enabled simple-dual-port RAM.
// Independent write (AW/W/B) and read (AR/R) engines; out-of-range word
// indices answer SLVERR (reads return zero data, writes change nothing).
//   ACLK, ARESETN          : clock, async active-low reset
//   AW*/W*/B*              : write address, data and response channels
//   AR*/R*                 : read address and data channels
module axi_lite_bram_wide
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 256
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic                    WVALID,
    output logic                    WREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    BVALID,
    input  logic                    BREADY,
    output logic [1:0]              BRESP,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP
);

    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB  = $clog2(NUM_BYTES);
    localparam int unsigned WIDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam int unsigned IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    function automatic logic in_range(input logic [WIDX_W-1:0] idx);
        return 32'(idx) < MEM_DEPTH;
    endfunction

    // Byte-offset bits carry no meaning for word indexing.
    logic unused_addr_c;
    assign unused_addr_c = ^{AWADDR, ARADDR};

    // ---------------- write engine ----------------
    wr_state_e             wr_state_q;
    logic                  awready_q, wready_q, aw_held_q, w_held_q;
    logic [WIDX_W-1:0]     aw_idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [NUM_BYTES-1:0]  wstrb_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic                  aw_hs_c, w_hs_c, aw_held_d, w_held_d, wr_in_range_c;

    assign aw_hs_c       = AWVALID && awready_q;
    assign w_hs_c        = WVALID && wready_q;
    assign aw_held_d     = aw_held_q || aw_hs_c;
    assign w_held_d      = w_held_q || w_hs_c;
    assign wr_in_range_c = in_range(aw_idx_q);

    // AW and W are collected in any order; the write fires once both are held.
    always_ff @(posedge ACLK or negedge ARESETN) begin : wr_fsm
        if (!ARESETN) begin
            wr_state_q <= WR_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else begin
            case (wr_state_q)
                WR_IDLE: begin
                    if (aw_hs_c) aw_idx_q <= AWADDR[ADDR_WIDTH-1:ADDR_LSB];
                    if (w_hs_c) begin
                        wdata_q <= WDATA;
                        wstrb_q <= WSTRB;
                    end
                    if (aw_held_d && w_held_d) begin
                        wr_state_q <= WR_EXEC;
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b0;
                        aw_held_q  <= 1'b0;
                        w_held_q   <= 1'b0;
                    end else begin
                        awready_q <= !aw_held_d;
                        wready_q  <= !w_held_d;
                        aw_held_q <= aw_held_d;
                        w_held_q  <= w_held_d;
                    end
                end
                WR_EXEC: begin
                    bvalid_q   <= 1'b1;
                    bresp_q    <= wr_in_range_c ? RESP_OKAY : RESP_SLVERR;
                    wr_state_q <= WR_RESP;
                end
                WR_RESP: begin
                    if (BREADY) begin
                        bvalid_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wready_q   <= 1'b1;
                        wr_state_q <= WR_IDLE;
                    end
                end
                default: wr_state_q <= WR_IDLE;
            endcase
        end
    end

    // ---------------- read engine ----------------
    rd_state_e         rd_state_q;
    logic              arready_q, rvalid_q;
    logic [WIDX_W-1:0] ar_idx_q;
    logic [1:0]        rresp_q;
    logic              ar_hs_c, rd_in_range_c;

    assign ar_hs_c       = ARVALID && arready_q;
    assign rd_in_range_c = in_range(ar_idx_q);

    // Address latch, one fetch cycle, then hold data until RREADY.
    always_ff @(posedge ACLK or negedge ARESETN) begin : rd_fsm
        if (!ARESETN) begin
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            ar_idx_q   <= '0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
        end else begin
            case (rd_state_q)
                RD_IDLE: begin
                    if (ar_hs_c) begin
                        ar_idx_q   <= ARADDR[ADDR_WIDTH-1:ADDR_LSB];
                        arready_q  <= 1'b0;
                        rd_state_q <= RD_FETCH;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                RD_FETCH: begin
                    rvalid_q   <= 1'b1;
                    rresp_q    <= rd_in_range_c ? RESP_OKAY : RESP_SLVERR;
                    rd_state_q <= RD_DATA;
                end
                RD_DATA: begin
                    if (RREADY) begin
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                        rd_state_q <= RD_IDLE;
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    // RAM read register doubles as RDATA; out-of-range fetches clear it.
    sdp_bram_be #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_ram (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .we_i    ((wr_state_q == WR_EXEC) && wr_in_range_c),
        .waddr_i (IDX_W'(aw_idx_q)),
        .wbe_i   (wstrb_q),
        .wdata_i (wdata_q),
        .re_i    (rd_state_q == RD_FETCH),
        .rclr_i  (!rd_in_range_c),
        .raddr_i (IDX_W'(ar_idx_q)),
        .rdata_o (RDATA)
    );

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_lite_bram_wide.sv
// Self-checking bench for axi_lite_bram_wide (32-bit data, 256 words).
// Reference model: a 1024-entry byte array, byte k initialised to k[7:0].
module tb_axi_lite_bram_wide;

    logic        ACLK;
    logic        ARESETN;
    logic        AWVALID, AWREADY;
    logic [11:0] AWADDR;
    logic        WVALID, WREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        BVALID, BREADY;
    logic [1:0]  BRESP;
    logic        ARVALID, ARREADY;
    logic [11:0] ARADDR;
    logic        RVALID, RREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;

    axi_lite_bram_wide #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .MEM_DEPTH(256)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    logic [7:0]  mem_m [1024];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_rdata;
    logic [1:0]  last_rresp;
    logic [1:0]  last_bresp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // 256 words x 4 bytes: a byte address is in range iff it is below 0x400.
    task automatic model_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] r);
        if (a[11:10] == 2'b00) begin
            d = {mem_m[{a[9:2], 2'd3}], mem_m[{a[9:2], 2'd2}],
                 mem_m[{a[9:2], 2'd1}], mem_m[{a[9:2], 2'd0}]};
            r = 2'b00;
        end else begin
            d = '0;
            r = 2'b10;
        end
    endtask

    task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                               output logic [1:0] r);
        if (a[11:10] == 2'b00) begin
            if (s[0]) mem_m[{a[9:2], 2'd0}] = d[7:0];
            if (s[1]) mem_m[{a[9:2], 2'd1}] = d[15:8];
            if (s[2]) mem_m[{a[9:2], 2'd2}] = d[23:16];
            if (s[3]) mem_m[{a[9:2], 2'd3}] = d[31:24];
            r = 2'b00;
        end else begin
            r = 2'b10;
        end
    endtask

    // One optional write and one optional read, run concurrently. Inputs change
    // and outputs are sampled on the falling edge. Delays count falling edges.
    task automatic txn(input bit do_wr, input logic [11:0] waddr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input int aw_dly, input int w_dly, input int b_dly,
                       input bit do_rd, input logic [11:0] raddr, input int ar_dly, input int r_dly);
        bit aw_go = 0, w_go = 0, b_go = 0, ar_go = 0, r_go = 0;
        bit aw_done = !do_wr, w_done = !do_wr, b_done = !do_wr;
        bit ar_done = !do_rd, r_done = !do_rd;
        bit b_seen = 0, r_seen = 0;
        int cyc = 0, ar_cyc = 0, b_hold = 0, r_hold = 0;
        logic [1:0]  b_first, rr_first, exp_b, exp_rr;
        logic [31:0] rd_first, exp_rd;
        while (!(aw_done && w_done && b_done && ar_done && r_done) && cyc < 300) begin
            @(negedge ACLK);
            if (aw_go) begin AWVALID = 0; aw_done = 1; aw_go = 0; end
            if (w_go)  begin WVALID = 0;  w_done = 1;  w_go = 0;  end
            if (ar_go) begin ARVALID = 0; ar_done = 1; ar_go = 0; end
            if (b_go) begin
                BREADY = 0; b_go = 0; b_done = 1;
                chk("bvalid_drop", 32'(BVALID), 0);
                chk("wr_ready_back", 32'({AWREADY, WREADY}), 32'h3);
            end
            if (r_go) begin
                RREADY = 0; r_go = 0; r_done = 1;
                chk("rvalid_drop", 32'(RVALID), 0);
                chk("arready_back", 32'(ARREADY), 1);
            end
            if (do_wr && aw_done && !b_done) chk("awready_low", 32'(AWREADY), 0);
            if (do_wr && w_done && !b_done)  chk("wready_low", 32'(WREADY), 0);
            if (do_rd && ar_done && !r_done) chk("arready_low", 32'(ARREADY), 0);
            // Read first: a read sampling on the same edge as a write commit sees old data.
            if (do_rd && ar_done && !r_done && !r_go && RVALID) begin
                if (!r_seen) begin
                    r_seen = 1;
                    model_read(raddr, exp_rd, exp_rr);
                    chk("r_latency", 32'(cyc - ar_cyc), 2);
                    chk("rdata", RDATA, exp_rd);
                    chk("rresp", 32'(RRESP), 32'(exp_rr));
                    rd_first = RDATA; rr_first = RRESP;
                    last_rdata = RDATA; last_rresp = RRESP;
                end else begin
                    chk("rdata_hold", RDATA, rd_first);
                    chk("rresp_hold", 32'(RRESP), 32'(rr_first));
                end
                if (r_hold >= r_dly) begin RREADY = 1; r_go = 1; end
                else r_hold++;
            end
            if (do_wr && aw_done && w_done && !b_done && !b_go && BVALID) begin
                if (!b_seen) begin
                    b_seen = 1;
                    model_write(waddr, wdata, wstrb, exp_b);
                    chk("bresp", 32'(BRESP), 32'(exp_b));
                    b_first = BRESP; last_bresp = BRESP;
                end else begin
                    chk("bresp_hold", 32'(BRESP), 32'(b_first));
                end
                if (b_hold >= b_dly) begin BREADY = 1; b_go = 1; end
                else b_hold++;
            end
            if (!aw_done && !aw_go && cyc >= aw_dly) begin AWVALID = 1; AWADDR = waddr; end
            if (!w_done && !w_go && cyc >= w_dly) begin WVALID = 1; WDATA = wdata; WSTRB = wstrb; end
            if (!ar_done && !ar_go && cyc >= ar_dly) begin ARVALID = 1; ARADDR = raddr; end
            if (AWVALID && AWREADY) aw_go = 1;
            if (WVALID && WREADY) w_go = 1;
            if (ARVALID && ARREADY && !ar_go) begin ar_go = 1; ar_cyc = cyc; end
            cyc++;
        end
        chk("txn_in_budget", 32'(cyc < 300), 1);
    endtask

    task automatic rd(input logic [11:0] a);
        txn(0, 12'h0, 32'h0, 4'h0, 0, 0, 0, 1, a, 0, 0);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int aw_dly, input int w_dly);
        txn(1, a, d, s, aw_dly, w_dly, 0, 0, 12'h0, 0, 0);
    endtask

    initial begin
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        int          mode;
        AWVALID = 0; AWADDR = '0; WVALID = 0; WDATA = '0; WSTRB = '0; BREADY = 0;
        ARVALID = 0; ARADDR = '0; RREADY = 0; ARESETN = 0;
        last_rdata = '0; last_rresp = '0; last_bresp = '0;
        for (int k = 0; k < 1024; k++) mem_m[10'(k)] = 8'(k);

        repeat (3) @(negedge ACLK);
        chk("rst_ready", 32'({AWREADY, WREADY, ARREADY}), 0);
        chk("rst_valid", 32'({BVALID, RVALID}), 0);
        chk("rst_resp", 32'({BRESP, RRESP}), 0);
        chk("rst_rdata", RDATA, 0);
        ARESETN = 1;
        @(negedge ACLK);
        chk("ready_after_rst", 32'({AWREADY, WREADY, ARREADY}), 32'h7);

        rd(12'h010);
        chk("plan_rd_010", last_rdata, 32'h13121110);
        chk("plan_rresp_010", 32'(last_rresp), 0);

        wr(12'h020, 32'hAABBCCDD, 4'b0101, 0, 0);
        chk("plan_bresp_020", 32'(last_bresp), 0);
        rd(12'h020);
        chk("plan_rd_020", last_rdata, 32'h23BB21DD);

        wr(12'h004, 32'h11223344, 4'hF, 3, 0);
        chk("plan_bresp_004", 32'(last_bresp), 0);
        rd(12'h004);
        chk("plan_rd_004", last_rdata, 32'h11223344);

        wr(12'h400, 32'hDEADBEEF, 4'hF, 0, 1);
        chk("plan_bresp_oor", 32'(last_bresp), 32'h2);
        rd(12'h400);
        chk("plan_rd_oor", last_rdata, 0);
        chk("plan_rresp_oor", 32'(last_rresp), 32'h2);
        rd(12'h000);
        chk("plan_no_alias", last_rdata, 32'h03020100);

        // Both response channels stalled for five cycles.
        txn(1, 12'h040, 32'h5A5A1234, 4'hF, 0, 0, 5, 1, 12'h044, 0, 5);
        rd(12'h040);
        chk("bp_rd_040", last_rdata, 32'h5A5A1234);

        // Same-word write and read launched together.
        txn(1, 12'h008, 32'hCAFEF00D, 4'hF, 0, 0, 0, 1, 12'h008, 0, 0);
        chk("collide_old", last_rdata, 32'h0B0A0908);
        rd(12'h008);
        chk("collide_new", last_rdata, 32'hCAFEF00D);

        wr(12'h00E, 32'hFFFFFFFF, 4'h0, 1, 0);
        chk("nostrb_bresp", 32'(last_bresp), 0);
        rd(12'h00C);
        chk("nostrb_rd", last_rdata, 32'h0F0E0D0C);

        for (int i = 0; i < 80; i++) begin
            mode = int'($urandom_range(0, 2));
            txn(mode != 1, 12'($urandom_range(0, 12'h47F)), $urandom, 4'($urandom_range(0, 15)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                mode != 0, 12'($urandom_range(0, 12'h47F)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
        end

        // Reset with a half-delivered write (AW only) and a read holding data.
        @(negedge ACLK);
        AWVALID = 1; AWADDR = 12'h030;
        ARVALID = 1; ARADDR = 12'h00C;
        @(negedge ACLK);
        AWVALID = 0; ARVALID = 0;
        chk("mid_awready", 32'(AWREADY), 0);
        @(negedge ACLK);
        model_read(12'h00C, exp_d, exp_r);
        chk("mid_rvalid", 32'(RVALID), 1);
        chk("mid_rdata", RDATA, exp_d);
        #2 ARESETN = 0;
        #1;
        chk("async_rvalid", 32'(RVALID), 0);
        chk("async_rdata", RDATA, 0);
        chk("async_ready", 32'({AWREADY, WREADY, ARREADY}), 0);
        @(negedge ACLK);
        ARESETN = 1;
        chk("release_ready", 32'({AWREADY, WREADY, ARREADY}), 0);
        @(negedge ACLK);
        chk("release_ready_next", 32'({AWREADY, WREADY, ARREADY}), 32'h7);
        rd(12'h030);
        model_read(12'h030, exp_d, exp_r);
        chk("dropped_write", last_rdata, exp_d);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_lite_bram_wide.md
Name: axi_lite_bram_wide

Overview:
AXI4-Lite slave fronting an on-chip simple-dual-port RAM. It generalises the 8-bit BRAM slave to any power-of-two data width with per-byte write strobes. It accepts AW and W independently, in any order. It returns SLVERR on out-of-range addresses and holds responses stable under back-pressure. It sits on the project AXI-Lite interconnect as a general scratch/data memory.

Parameters:
ADDR_WIDTH, 12, byte-address width on AWADDR/ARADDR
DATA_WIDTH, 32, bus and memory word width; one of 8/16/32/64
MEM_DEPTH, 256, number of DATA_WIDTH words implemented; must be ≤ 2^(ADDR_WIDTH-ADDR_LSB)
ADDR_LSB (localparam), log2(DATA_WIDTH/8), byte-offset bits ignored for word indexing

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESETN  in  1  asynchronous active-low reset
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
AWADDR  in  ADDR_WIDTH  write byte address
WVALID  in  1  write data valid
WREADY  out  1  write data ready
WDATA  in  DATA_WIDTH  write data
WSTRB  in  DATA_WIDTH/8  byte-lane enables
BVALID  out  1  write response valid
BREADY  in  1  write response ready
BRESP  out  2  write response
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
ARADDR  in  ADDR_WIDTH  read byte address
RVALID  out  1  read data valid
RREADY  in  1  read data ready
RDATA  out  DATA_WIDTH  read data
RRESP  out  2  read response

Behaviour:
- Single clock ACLK; reset ARESETN is asynchronous, active-low.
- Reset values: AWREADY=WREADY=ARREADY=0, BVALID=0, BRESP=00, RVALID=0, RDATA=0, RRESP=00. Reset does not clear memory contents.
- First cycle after reset release: AWREADY=WREADY=ARREADY=1.
- Word index = addr[ADDR_WIDTH-1:ADDR_LSB]. In range iff index < MEM_DEPTH. Low ADDR_LSB bits are ignored; no misalignment error.
- Memory init: byte k of the memory holds k[7:0]. For 32-bit, word i = {4i+3, 4i+2, 4i+1, 4i} (low 8 bits of each).
- Write path FSM:
  - WR_IDLE: AWREADY=1 until AW handshake, then address latched and AWREADY=0. WREADY=1 until W handshake, then data and strobe latched and WREADY=0. Handshakes may occur in the same cycle or in either order, any gap.
  - When both are held, next state is WR_EXEC (1 cycle). If in range, write the bytes whose WSTRB bit=1 and set BRESP=00. If out of range, write nothing and set BRESP=10. Assert BVALID.
  - WR_RESP: BVALID, BRESP held stable until BREADY. On BVALID&&BREADY go to WR_IDLE with AWREADY=WREADY=1 on the following cycle. No new AW/W is accepted while a write is outstanding.
  - WSTRB=0 is a legal no-op write with BRESP=00.
- Read path FSM:
  - RD_IDLE: ARREADY=1; AR handshake latches the address, ARREADY=0.
  - RD_FETCH (1 cycle): registered RAM read.
  - RD_DATA: RVALID=1 with RDATA and RRESP. In range: RRESP=00. Out of range: RDATA=0, RRESP=10.
  - RDATA/RRESP held stable until RREADY. On handshake, RVALID=0 and return to RD_IDLE.
  - Latency: AR handshake at cycle n gives RVALID at n+2. Sustained throughput is one read per 3 cycles with RREADY tied high.
- Read and write paths are fully independent and may run concurrently.
- Same-word collision: RD_FETCH and WR_EXEC in the same cycle returns the old data (read-before-write).
- Reset asserted mid-transaction: both FSMs return to idle immediately and all outputs take reset values. The in-flight write is dropped if WR_EXEC was not reached.
- VALID outputs never depend combinationally on READY inputs.

Decomposition:
- Package axi_lite_pkg holds:
  - constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - write-FSM state encoding WR_IDLE/WR_EXEC/WR_RESP and read-FSM encoding RD_IDLE/RD_FETCH/RD_DATA
- Sub-module sdp_bram_be: one write port with byte enables, one registered read port, read-before-write. Parameterised by DATA_WIDTH and MEM_DEPTH; contains the init loop.

Test Plan:
- Reset and read: release reset, read ARADDR=0x010 (DATA_WIDTH=32) -> RVALID 2 cycles after the AR handshake, RDATA=0x13121110, RRESP=00.
- Strobed write: AW 0x020 and W 0xAABBCCDD with WSTRB=0101 in the same cycle -> BRESP=00. Readback of 0x020 gives 0x23BB21DD.
- W before AW: W 0x11223344 (WSTRB=1111) presented 3 cycles before AW 0x004 -> a single BVALID after both, BRESP=00. Readback gives 0x11223344.
- Out of range: write 0x400 (MEM_DEPTH=256) -> BRESP=10 and no memory change. Read 0x400 -> RDATA=0, RRESP=10.
- Back-pressure: hold BREADY=0 and RREADY=0 for 5 cycles -> BVALID/BRESP and RVALID/RDATA/RRESP held constant; AWREADY=WREADY=ARREADY stay 0 until the handshakes.
- Collision and reset: concurrent write/read of word 0x008 -> read returns old 0x0B0A0908, then new value on re-read. Assert ARESETN mid-read -> RVALID=0 asynchronously and ARREADY=1 one cycle after release.
